// File: rtl/period_timer_arbiter_pkg.sv
// Shared types and helpers for the round-robin period timer arbiter.
package period_timer_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} arb_state_t;

    localparam int MAX_REQ = 64;
    localparam logic [MAX_REQ-1:0] ONEHOT_ZERO = '0;

    // Index width for a requester count; a lone requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/period_timer_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after the pointer.
module period_timer_arbiter_rr_pick
    import period_timer_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic             o_valid,
    output logic [IW-1:0]    o_idx,
    output logic [N_REQ-1:0] o_onehot
);

    always_comb begin
        int j;
        j        = 0;
        o_valid  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(i_ptr) + k) % N_REQ;
            if (!o_valid && i_req[j]) begin
                o_valid     = 1'b1;
                o_idx       = IW'(j);
                o_onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/period_timer_arbiter.sv
// One shared period counter granted round-robin to N_REQ requesters; pulses the owner's done bit.
module period_timer_arbiter
    import period_timer_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [N_REQ-1:0]       req_in,
    input  logic [N_REQ*WIDTH-1:0] period_in,
    output logic [N_REQ-1:0]       grant_out,
    output logic [WIDTH-1:0]       count_out,
    output logic                   busy_out,
    output logic [N_REQ-1:0]       done_out,
    output logic                   abort_out
);

    localparam int IW = idx_w(N_REQ);
    localparam logic [N_REQ-1:0] GRANT_NONE = ONEHOT_ZERO[N_REQ-1:0];

    arb_state_t         r_state, w_state_nxt;
    logic [IW-1:0]      r_ptr, w_ptr_nxt;
    logic [IW-1:0]      r_owner, w_owner_nxt;
    logic [WIDTH-1:0]   r_period, w_period_nxt;
    logic [WIDTH-1:0]   r_count, w_count_nxt;
    logic [N_REQ-1:0]   r_grant, w_grant_nxt;
    logic [N_REQ-1:0]   r_done, w_done_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_abort, w_abort_nxt;

    logic               w_win_vld;
    logic [IW-1:0]      w_win_idx;
    logic [N_REQ-1:0]   w_win_onehot;
    logic [WIDTH-1:0]   w_sel_period;

    period_timer_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .i_req    (req_in),
        .i_ptr    (r_ptr),
        .o_valid  (w_win_vld),
        .o_idx    (w_win_idx),
        .o_onehot (w_win_onehot)
    );

    assign w_sel_period = period_in[int'(w_win_idx)*WIDTH +: WIDTH];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state  <= IDLE;
            r_ptr    <= IW'(N_REQ - 1);
            r_owner  <= '0;
            r_period <= '0;
            r_count  <= '0;
            r_grant  <= GRANT_NONE;
            r_done   <= GRANT_NONE;
            r_busy   <= 1'b0;
            r_abort  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_owner  <= w_owner_nxt;
            r_period <= w_period_nxt;
            r_count  <= w_count_nxt;
            r_grant  <= w_grant_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
            r_abort  <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_owner_nxt  = r_owner;
        w_period_nxt = r_period;
        w_count_nxt  = r_count;
        w_grant_nxt  = r_grant;
        w_busy_nxt   = r_busy;
        w_done_nxt   = GRANT_NONE;
        w_abort_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt  = COUNT;
                    w_grant_nxt  = w_win_onehot;
                    w_ptr_nxt    = w_win_idx;
                    w_owner_nxt  = w_win_idx;
                    // A zero period would never terminate, so it runs as one count.
                    w_period_nxt = (w_sel_period == '0) ? WIDTH'(1) : w_sel_period;
                    w_count_nxt  = '0;
                    w_busy_nxt   = 1'b1;
                end
            end
            COUNT: begin
                if (!req_in[r_owner]) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = GRANT_NONE;
                    w_count_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_abort_nxt = 1'b1;
                end else if (r_count == r_period - WIDTH'(1)) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = r_grant;
                    w_grant_nxt = GRANT_NONE;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + WIDTH'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = GRANT_NONE;
                w_count_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign grant_out = r_grant;
    assign count_out = r_count;
    assign busy_out  = r_busy;
    assign done_out  = r_done;
    assign abort_out = r_abort;

endmodule

// File: tb/tb_period_timer_arbiter.sv
// Bench for period_timer_arbiter: job-level reference model checked every cycle plus directed literal checks.
module tb_period_timer_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk_in = 1'b0;
    logic           rst_in = 1'b1;
    logic [N-1:0]   req_in = '0;
    logic [N*W-1:0] period_in = '0;
    logic [N-1:0]   grant_out;
    logic [W-1:0]   count_out;
    logic           busy_out;
    logic [N-1:0]   done_out;
    logic           abort_out;

    always #5 clk_in = ~clk_in;

    period_timer_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .req_in    (req_in),
        .period_in (period_in),
        .grant_out (grant_out),
        .count_out (count_out),
        .busy_out  (busy_out),
        .done_out  (done_out),
        .abort_out (abort_out)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit m_en     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Job-level model: who owns the counter, how far into its job, and any pending pulse.
    int     m_owner = -1;
    int     m_ptr   = N - 1;
    int     m_done  = -1;
    longint m_cnt   = 0;
    longint m_p     = 0;
    bit     m_abort = 1'b0;

    function automatic int pick(input int ptr, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++)
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic longint eff_period(input logic [N*W-1:0] pv, input int w);
        longint v;
        v = longint'(pv[w*W +: W]);
        return (v == 0) ? 1 : v;
    endfunction

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            m_owner <= -1;
            m_ptr   <= N - 1;
            m_done  <= -1;
            m_cnt   <= 0;
            m_p     <= 0;
            m_abort <= 1'b0;
        end else begin
            m_abort <= 1'b0;
            m_done  <= -1;
            if (m_done >= 0) begin
                m_cnt <= 0;
            end else if (m_owner < 0) begin
                if (pick(m_ptr, req_in) >= 0) begin
                    m_owner <= pick(m_ptr, req_in);
                    m_ptr   <= pick(m_ptr, req_in);
                    m_cnt   <= 0;
                    m_p     <= eff_period(period_in, pick(m_ptr, req_in));
                end
            end else if (!req_in[m_owner]) begin
                m_abort <= 1'b1;
                m_owner <= -1;
                m_cnt   <= 0;
            end else if (m_cnt == m_p - 1) begin
                m_done  <= m_owner;
                m_owner <= -1;
                m_cnt   <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk_in) begin
        if (m_en) begin
            chk("model_grant", 64'(grant_out), (m_owner >= 0) ? 64'(1) << m_owner : 64'(0));
            chk("model_count", 64'(count_out), (m_owner >= 0) ? 64'(m_cnt) : 64'(0));
            chk("model_busy",  64'(busy_out),  64'((m_owner >= 0) || (m_done >= 0)));
            chk("model_done",  64'(done_out),  (m_done >= 0) ? 64'(1) << m_done : 64'(0));
            chk("model_abort", 64'(abort_out), 64'(m_abort));
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic do_reset();
        req_in    = '0;
        period_in = '0;
        rst_in    = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
    endtask

    task automatic set_period(input int idx, input int val);
        period_in[idx*W +: W] = W'(val);
    endtask

    int g_cyc[8];
    logic [N-1:0] g_val[8];
    int n_g;
    logic [N-1:0] prev_g;

    initial begin
        #1 rst_in = 1'b0;
        #2 m_en = 1'b1;
        tick();
        chk("rst_grant", 64'(grant_out), 64'(0));
        chk("rst_count", 64'(count_out), 64'(0));
        chk("rst_busy",  64'(busy_out),  64'(0));
        chk("rst_done",  64'(done_out),  64'(0));
        chk("rst_abort", 64'(abort_out), 64'(0));
        rst_in = 1'b1;

        // Single job, period 5
        set_period(0, 5);
        req_in = 4'b0001;
        tick();
        chk("t1_grant", 64'(grant_out), 64'(1));
        chk("t1_count0", 64'(count_out), 64'(0));
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t1_count", 64'(count_out), 64'(i));
        end
        tick();
        chk("t1_done", 64'(done_out), 64'(1));
        chk("t1_grant_off", 64'(grant_out), 64'(0));
        chk("t1_busy_in_done", 64'(busy_out), 64'(1));
        req_in = '0;
        tick();
        chk("t1_done_off", 64'(done_out), 64'(0));
        chk("t1_busy_off", 64'(busy_out), 64'(0));

        // Two requesters held, period 3: alternating grants every 5 cycles
        do_reset();
        for (int i = 0; i < N; i++) set_period(i, 3);
        req_in = 4'b0101;
        n_g = 0;
        prev_g = '0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (grant_out != '0 && prev_g == '0 && n_g < 8) begin
                g_cyc[n_g] = c;
                g_val[n_g] = grant_out;
                n_g++;
            end
            prev_g = grant_out;
        end
        req_in = '0;
        chk("t2_ngrants", 64'(n_g >= 4), 64'(1));
        if (n_g >= 4) begin
            chk("t2_g0", 64'(g_val[0]), 64'(4'b0001));
            chk("t2_g1", 64'(g_val[1]), 64'(4'b0100));
            chk("t2_g2", 64'(g_val[2]), 64'(4'b0001));
            chk("t2_g3", 64'(g_val[3]), 64'(4'b0100));
            chk("t2_first_cyc", 64'(g_cyc[0]), 64'(1));
            chk("t2_space1", 64'(g_cyc[1] - g_cyc[0]), 64'(5));
            chk("t2_space2", 64'(g_cyc[2] - g_cyc[1]), 64'(5));
            chk("t2_space3", 64'(g_cyc[3] - g_cyc[2]), 64'(5));
        end
        tick();
        tick();

        // Zero period runs as one count
        do_reset();
        set_period(0, 0);
        req_in = 4'b0001;
        tick();
        chk("t3_grant", 64'(grant_out), 64'(1));
        chk("t3_count", 64'(count_out), 64'(0));
        tick();
        chk("t3_done", 64'(done_out), 64'(1));
        req_in = '0;
        tick();
        chk("t3_done_off", 64'(done_out), 64'(0));

        // Abort at count 4
        do_reset();
        set_period(0, 10);
        req_in = 4'b0001;
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("t4_count4", 64'(count_out), 64'(4));
        req_in = '0;
        tick();
        chk("t4_abort", 64'(abort_out), 64'(1));
        chk("t4_no_done", 64'(done_out), 64'(0));
        chk("t4_grant", 64'(grant_out), 64'(0));
        chk("t4_busy", 64'(busy_out), 64'(0));
        tick();
        chk("t4_abort_off", 64'(abort_out), 64'(0));

        // Async reset at count 7, then requester 0 wins first
        do_reset();
        set_period(0, 10);
        req_in = 4'b0001;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("t5_count7", 64'(count_out), 64'(7));
        #1 rst_in = 1'b0;
        #1;
        chk("t5_grant", 64'(grant_out), 64'(0));
        chk("t5_count", 64'(count_out), 64'(0));
        chk("t5_busy",  64'(busy_out),  64'(0));
        chk("t5_done",  64'(done_out),  64'(0));
        chk("t5_abort", 64'(abort_out), 64'(0));
        req_in = 4'b1111;
        tick();
        rst_in = 1'b1;
        tick();
        chk("t5_first_grant", 64'(grant_out), 64'(1));
        req_in = '0;
        tick();
        tick();

        // Period change mid-job is ignored
        do_reset();
        set_period(0, 6);
        req_in = 4'b0001;
        tick();
        tick();
        chk("t6_count1", 64'(count_out), 64'(1));
        set_period(0, 2);
        for (int i = 0; i < 4; i++) tick();
        chk("t6_count5", 64'(count_out), 64'(5));
        chk("t6_no_done_yet", 64'(done_out), 64'(0));
        tick();
        chk("t6_done", 64'(done_out), 64'(1));
        req_in = '0;
        tick();
        tick();

        m_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
